// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-port memory between instruction fetch and
//               data load/store. Data has fixed priority, with a starvation
//               guard for fetch and a timeout abort for stalled accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic          f_err,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic [1:0]    owner
);

    localparam int c_SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int c_WCW = $clog2(TIMEOUT + 1);

    localparam logic [c_SCW-1:0] c_STARVE_MAX = c_SCW'(STARVE_MAX);
    localparam logic [c_WCW-1:0] c_TIMEOUT    = c_WCW'(TIMEOUT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [1:0] c_OWN_NONE  = 2'b00;
    localparam logic [1:0] c_OWN_FETCH = 2'b01;
    localparam logic [1:0] c_OWN_DATA  = 2'b10;

    logic [1:0]       r_state;
    logic [c_SCW-1:0] r_starve_cnt;
    logic [c_WCW-1:0] r_wait_cnt;
    logic             r_we;

    logic             w_grant_f;
    logic             w_done;
    logic             w_err;
    logic [DW-1:0]    w_rdata;

    // Fetch wins when alone, or when data has already starved it long enough.
    assign w_grant_f = f_req && (!d_req || (r_starve_cnt == c_STARVE_MAX));

    assign w_done  = mem_ack || (r_wait_cnt == c_TIMEOUT);
    assign w_err   = !mem_ack;
    assign w_rdata = mem_ack ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
            r_we         <= 1'b0;
            f_ack        <= 1'b0;
            f_err        <= 1'b0;
            f_rdata      <= '0;
            d_ack        <= 1'b0;
            d_err        <= 1'b0;
            d_rdata      <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            owner        <= c_OWN_NONE;
        end else begin
            f_ack <= 1'b0;
            f_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (f_req || d_req) begin
                        r_state <= c_ISSUE;
                        busy    <= 1'b1;
                        mem_en  <= 1'b1;
                        if (w_grant_f) begin
                            r_we         <= 1'b0;
                            mem_we       <= 1'b0;
                            mem_addr     <= f_addr;
                            mem_wdata    <= '0;
                            owner        <= c_OWN_FETCH;
                            r_starve_cnt <= '0;
                        end else begin
                            r_we      <= d_we;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            owner     <= c_OWN_DATA;
                            if (f_req && (r_starve_cnt != c_STARVE_MAX)) begin
                                r_starve_cnt <= r_starve_cnt + 1'b1;
                            end
                        end
                    end
                end
                c_ISSUE: begin
                    mem_en     <= 1'b0;
                    mem_we     <= 1'b0;
                    r_wait_cnt <= c_WCW'(1);
                    r_state    <= c_WAIT;
                end
                c_WAIT: begin
                    if (w_done) begin
                        r_state <= c_RESP;
                        if (owner == c_OWN_FETCH) begin
                            f_ack   <= 1'b1;
                            f_err   <= w_err;
                            f_rdata <= w_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            d_err <= w_err;
                            // A write completion leaves the last read data visible.
                            if (!r_we) begin
                                d_rdata <= w_rdata;
                            end
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                c_RESP: begin
                    r_state    <= c_IDLE;
                    r_wait_cnt <= '0;
                    busy       <= 1'b0;
                    owner      <= c_OWN_NONE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scoreboard bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_ack, f_err;
    logic [15:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack, d_err;
    logic [15:0] d_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack_resp = 1'b0;
    logic        mem_ack_late = 1'b0;
    logic        busy;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(16), .DW(16), .STARVE_MAX(3), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack_resp | mem_ack_late),
        .busy(busy), .owner(owner)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  owner;
    } issue_t;

    typedef struct packed {
        logic        is_data;
        logic        err;
        logic [15:0] rdata;
    } resp_t;

    issue_t iss_q[$];
    resp_t  rsp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     mem_lat = 1;
    bit     mem_no_ack = 1'b0;

    function automatic logic [15:0] mem_img(input logic [15:0] a);
        case (a)
            16'h0010: return 16'h4A0B;
            16'h0020: return 16'h1111;
            16'h0030: return 16'h2222;
            16'h0040: return 16'h7E57;
            16'h0300: return 16'hBEEF;
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model: acks mem_lat cycles after the ISSUE cycle.
    always begin : responder
        logic [15:0] ra;
        logic        rd;
        @(negedge clk);
        if (mem_en && !mem_no_ack) begin
            ra = mem_addr;
            rd = !mem_we;
            repeat (mem_lat) @(negedge clk);
            mem_rdata    = rd ? mem_img(ra) : 16'hDEAD;
            mem_ack_resp = 1'b1;
            @(negedge clk);
            mem_ack_resp = 1'b0;
            mem_rdata    = '0;
        end
    end

    always @(negedge clk) begin : monitor
        issue_t ie;
        resp_t  re;
        if (mem_en) begin
            if (iss_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual=addr %h required=none", mem_addr);
            end else begin
                ie = iss_q.pop_front();
                check("issue", 64'({mem_we, mem_addr, mem_wdata, owner}), 64'(ie));
                check("issue_busy", 64'(busy), 64'(1));
            end
        end
        if (f_ack || d_ack) begin
            check("ack_exclusive", 64'(f_ack & d_ack), 64'(0));
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=f%0b d%0b required=none", f_ack, d_ack);
            end else begin
                re = rsp_q.pop_front();
                if (re.is_data)
                    check("d_resp", 64'({d_ack, d_err, d_rdata}), 64'({1'b1, re.err, re.rdata}));
                else
                    check("f_resp", 64'({f_ack, f_err, f_rdata}), 64'({1'b1, re.err, re.rdata}));
            end
        end
    end

    task automatic run_fetch(input logic [15:0] a, output int lat);
        f_addr = a;
        f_req  = 1'b1;
        lat    = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!f_ack && lat < 100);
        f_req = 1'b0;
        if (!f_ack) begin
            checks++;
            errors++;
            $display("FAIL fetch_wait actual=no_ack required=f_ack");
        end
    endtask

    task automatic run_data(input logic we, input logic [15:0] a, input logic [15:0] wd,
                            output int lat);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        lat     = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d_ack && lat < 100);
        d_req = 1'b0;
        if (!d_ack) begin
            checks++;
            errors++;
            $display("FAIL data_wait actual=no_ack required=d_ack");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lf, ld, n, nd;
        repeat (3) @(negedge clk);
        check("rst_fetch", 64'({f_ack, f_err, f_rdata}), 64'(0));
        check("rst_data", 64'({d_ack, d_err, d_rdata}), 64'(0));
        check("rst_mem", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'(0));
        check("rst_busy_owner", 64'({busy, owner}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Basic fetch with zero-wait memory
        iss_q.push_back('{1'b0, 16'h0010, 16'h0000, 2'b01});
        rsp_q.push_back('{1'b0, 1'b0, 16'h4A0B});
        run_fetch(16'h0010, lat);
        check("t1_latency", 64'(lat), 64'(3));
        @(negedge clk);
        check("t1_busy_idle", 64'({busy, owner}), 64'(0));

        // Contention: data write first, then fetch
        iss_q.push_back('{1'b1, 16'h0200, 16'h1234, 2'b10});
        iss_q.push_back('{1'b0, 16'h0040, 16'h0000, 2'b01});
        rsp_q.push_back('{1'b1, 1'b0, 16'h0000});
        rsp_q.push_back('{1'b0, 1'b0, 16'h7E57});
        fork
            run_data(1'b1, 16'h0200, 16'h1234, ld);
            run_fetch(16'h0040, lf);
        join
        check("t2_data_latency", 64'(ld), 64'(3));
        check("t2_fetch_latency", 64'(lf), 64'(7));
        @(negedge clk);

        // Starvation guard: three data wins, then fetch
        for (int i = 0; i < 3; i++) begin
            iss_q.push_back('{1'b0, 16'h0020, 16'h0000, 2'b10});
            rsp_q.push_back('{1'b1, 1'b0, 16'h1111});
        end
        iss_q.push_back('{1'b0, 16'h0030, 16'h0000, 2'b01});
        rsp_q.push_back('{1'b0, 1'b0, 16'h2222});
        d_we = 1'b0; d_addr = 16'h0020; d_wdata = 16'h0000; f_addr = 16'h0030;
        f_req = 1'b1; d_req = 1'b1;
        n = 0; nd = 0;
        do begin
            @(negedge clk);
            n++;
            if (d_ack) nd++;
        end while (!f_ack && n < 100);
        f_req = 1'b0; d_req = 1'b0;
        check("t3_fetch_ack", 64'(f_ack), 64'(1));
        check("t3_data_wins", 64'(nd), 64'(3));
        check("t3_fetch_latency", 64'(n), 64'(15));
        check("t3_starve_clr", 64'(dut.r_starve_cnt), 64'(0));
        @(negedge clk);

        // Timeout on fetch, then a late mem_ack
        mem_no_ack = 1'b1;
        iss_q.push_back('{1'b0, 16'h0050, 16'h0000, 2'b01});
        rsp_q.push_back('{1'b0, 1'b1, 16'h0000});
        run_fetch(16'h0050, lat);
        check("t4_timeout_latency", 64'(lat), 64'(17));
        mem_ack_late = 1'b1;
        mem_rdata    = 16'hFFFF;
        @(negedge clk);
        mem_ack_late = 1'b0;
        mem_rdata    = '0;
        check("t4_busy_after", 64'(busy), 64'(0));
        @(negedge clk);
        check("t4_no_extra_ack", 64'({f_ack, d_ack, busy}), 64'(0));

        // Reset while a data read sits in WAIT
        iss_q.push_back('{1'b0, 16'h0300, 16'h0000, 2'b10});
        d_we = 1'b0; d_addr = 16'h0300; d_wdata = 16'h0000; d_req = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_in_wait", 64'({busy, owner, mem_en}), 64'({1'b1, 2'b10, 1'b0}));
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("t5_rst_outs", 64'({f_ack, f_err, d_ack, d_err, mem_en, mem_we, busy, owner}), 64'(0));
        check("t5_rst_data", 64'({f_rdata, d_rdata, mem_addr}), 64'(0));
        rst = 1'b0; mem_no_ack = 1'b0;
        repeat (2) @(negedge clk);
        iss_q.push_back('{1'b0, 16'h0300, 16'h0000, 2'b10});
        rsp_q.push_back('{1'b1, 1'b0, 16'hBEEF});
        run_data(1'b0, 16'h0300, 16'h0000, lat);
        check("t5_read_latency", 64'(lat), 64'(3));
        @(negedge clk);

        // Write ack holds the previous read data
        iss_q.push_back('{1'b1, 16'h0301, 16'h5555, 2'b10});
        rsp_q.push_back('{1'b1, 1'b0, 16'hBEEF});
        run_data(1'b1, 16'h0301, 16'h5555, lat);
        check("t6_write_latency", 64'(lat), 64'(3));

        repeat (3) @(negedge clk);
        check("issue_queue_empty", 64'(iss_q.size()), 64'(0));
        check("resp_queue_empty", 64'(rsp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
